// File: rtl/control_fsm_pkg.sv
// control_fsm_pkg: RV32I encodings, mux-select enums and FSM states shared by the control sequencer.
package control_fsm_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        f3_lb = 3'b000, f3_lh = 3'b001, f3_lw = 3'b010, f3_lbu = 3'b100, f3_lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {f3_sb = 3'b000, f3_sh = 3'b001, f3_sw = 3'b010} store_funct3_t;

    typedef enum logic [2:0] {
        f3_add, f3_sll, f3_slt, f3_sltu, f3_xor, f3_sr, f3_or, f3_and
    } arith_funct3_t;

    typedef enum logic [2:0] {
        alu_add, alu_sll, alu_sra, alu_sub, alu_xor, alu_srl, alu_or, alu_and
    } alu_ops;

    typedef enum logic [1:0] {pcmux_pc4, pcmux_alu, pcmux_alu_mod2} pcmux_sel_t;
    typedef enum logic {alumux1_rs1, alumux1_pc} alumux1_sel_t;
    typedef enum logic [2:0] {
        alumux2_i_imm, alumux2_u_imm, alumux2_b_imm, alumux2_s_imm, alumux2_j_imm, alumux2_rs2
    } alumux2_sel_t;
    typedef enum logic [3:0] {
        rfmux_alu, rfmux_br_en, rfmux_u_imm, rfmux_lw, rfmux_pc4,
        rfmux_lb, rfmux_lbu, rfmux_lh, rfmux_lhu
    } regfilemux_sel_t;
    typedef enum logic {marmux_pc, marmux_alu} marmux_sel_t;
    typedef enum logic {cmpmux_rs2, cmpmux_i_imm} cmpmux_sel_t;

    typedef enum logic [4:0] {
        s_fetch1, s_fetch2, s_fetch3, s_decode, s_imm, s_reg, s_br, s_lui, s_auipc,
        s_jal, s_jalr, s_calc_addr, s_ld1, s_ld2, s_st1, s_st2, s_illegal
    } state_t;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
        return f3 == f3_sb ? 4'b0001 << lo : f3 == f3_sh ? 4'b0011 << lo : 4'b1111;
    endfunction

    function automatic logic [3:0] load_rfmux(input logic [2:0] f3);
        case (f3)
            f3_lb:   return rfmux_lb;
            f3_lh:   return rfmux_lh;
            f3_lbu:  return rfmux_lbu;
            f3_lhu:  return rfmux_lhu;
            default: return rfmux_lw;
        endcase
    endfunction

endpackage

// File: rtl/control_fsm.sv
// control_fsm: multicycle RV32I sequencer; Moore outputs drive datapath loads, selects and the memory handshake.
module control_fsm
    import control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       br_en,
    input  logic [1:0] mem_addr_lo,
    input  logic       mem_resp,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_regfile,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_data_out,
    output logic [1:0] pcmux_sel,
    output logic       alumux1_sel,
    output logic [2:0] alumux2_sel,
    output logic [3:0] regfilemux_sel,
    output logic       marmux_sel,
    output logic       cmpmux_sel,
    output logic [2:0] aluop,
    output logic [2:0] cmpop,
    output logic       mem_read,
    output logic       mem_write,
    output logic [3:0] mem_byte_enable,
    output logic       commit
);
    state_t state, next;
    logic is_slt, is_store, alt;
    logic unused_funct7;

    assign alt = funct7[5];
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};
    assign is_slt = funct3 == f3_slt || funct3 == f3_sltu;
    assign is_store = opcode == op_store;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= s_fetch1;
        else state <= next;

    always_comb begin
        next = state;
        case (state)
            s_fetch1:    next = s_fetch2;
            s_fetch2:    next = mem_resp ? s_fetch3 : s_fetch2;
            s_fetch3:    next = s_decode;
            s_decode:
                case (opcode)
                    op_imm:            next = s_imm;
                    op_reg:            next = s_reg;
                    op_br:             next = s_br;
                    op_lui:            next = s_lui;
                    op_auipc:          next = s_auipc;
                    op_jal:            next = s_jal;
                    op_jalr:           next = s_jalr;
                    op_load, op_store: next = s_calc_addr;
                    default:           next = s_illegal;
                endcase
            s_calc_addr: next = is_store ? s_st1 : s_ld1;
            s_ld1:       next = mem_resp ? s_ld2 : s_ld1;
            s_st1:       next = mem_resp ? s_st2 : s_st1;
            default:     next = s_fetch1;
        endcase
    end

    always_comb begin
        load_pc = 1'b0;
        load_ir = 1'b0;
        load_regfile = 1'b0;
        load_mar = 1'b0;
        load_mdr = 1'b0;
        load_data_out = 1'b0;
        pcmux_sel = pcmux_pc4;
        alumux1_sel = alumux1_rs1;
        alumux2_sel = alumux2_i_imm;
        regfilemux_sel = rfmux_alu;
        marmux_sel = marmux_pc;
        cmpmux_sel = cmpmux_rs2;
        aluop = alu_add;
        cmpop = beq;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_byte_enable = 4'b1111;
        commit = 1'b0;
        case (state)
            s_fetch1: load_mar = 1'b1;
            s_fetch2: begin
                mem_read = 1'b1;
                load_mdr = 1'b1;
            end
            s_fetch3: load_ir = 1'b1;
            s_imm, s_reg: begin
                // slt* ride the comparator; the ALU result is ignored for them
                alumux2_sel = state == s_reg ? alumux2_rs2 : alumux2_i_imm;
                aluop = alt && funct3 == f3_sr ? alu_sra
                      : state == s_reg && alt && funct3 == f3_add ? alu_sub : funct3;
                cmpmux_sel = is_slt && state == s_imm;
                cmpop = !is_slt ? beq : funct3 == f3_slt ? blt : bltu;
                regfilemux_sel = is_slt ? rfmux_br_en : rfmux_alu;
                load_regfile = 1'b1;
                load_pc = 1'b1;
                commit = 1'b1;
            end
            s_br: begin
                cmpop = funct3;
                alumux1_sel = alumux1_pc;
                alumux2_sel = alumux2_b_imm;
                pcmux_sel = br_en ? pcmux_alu : pcmux_pc4;
                load_pc = 1'b1;
                commit = 1'b1;
            end
            s_lui: begin
                regfilemux_sel = rfmux_u_imm;
                load_regfile = 1'b1;
                load_pc = 1'b1;
                commit = 1'b1;
            end
            s_auipc: begin
                alumux1_sel = alumux1_pc;
                alumux2_sel = alumux2_u_imm;
                load_regfile = 1'b1;
                load_pc = 1'b1;
                commit = 1'b1;
            end
            s_jal, s_jalr: begin
                regfilemux_sel = rfmux_pc4;
                alumux1_sel = state == s_jal ? alumux1_pc : alumux1_rs1;
                alumux2_sel = state == s_jal ? alumux2_j_imm : alumux2_i_imm;
                pcmux_sel = state == s_jal ? pcmux_alu : pcmux_alu_mod2;
                load_regfile = 1'b1;
                load_pc = 1'b1;
                commit = 1'b1;
            end
            s_calc_addr: begin
                alumux2_sel = is_store ? alumux2_s_imm : alumux2_i_imm;
                marmux_sel = marmux_alu;
                load_mar = 1'b1;
                load_data_out = is_store;
            end
            s_ld1: begin
                mem_read = 1'b1;
                load_mdr = 1'b1;
            end
            s_ld2: begin
                regfilemux_sel = load_rfmux(funct3);
                load_regfile = 1'b1;
                load_pc = 1'b1;
                commit = 1'b1;
            end
            s_st1: begin
                mem_write = 1'b1;
                mem_byte_enable = store_be(funct3, mem_addr_lo);
            end
            s_st2, s_illegal: begin
                load_pc = 1'b1;
                commit = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed and randomized instruction streams checked against a per-instruction expectation model.
module tb_control_fsm;
    logic       clk = 1'b0, rst = 1'b1;
    logic [6:0] opcode = '0, funct7 = '0;
    logic [2:0] funct3 = '0;
    logic       br_en = 1'b0, mem_resp = 1'b0;
    logic [1:0] mem_addr_lo = '0;
    logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
    logic [1:0] pcmux_sel;
    logic       alumux1_sel, marmux_sel, cmpmux_sel;
    logic [2:0] alumux2_sel, aluop, cmpop;
    logic [3:0] regfilemux_sel, mem_byte_enable;
    logic       mem_read, mem_write, commit;
    int passed = 0, failed = 0, total = 0;

    localparam logic [6:0] OP_IMM = 7'b0010011, OP_REG = 7'b0110011, OP_BR = 7'b1100011,
        OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
        OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
    logic [6:0] legal_ops [9] = '{OP_IMM, OP_REG, OP_BR, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_STORE};
    logic [6:0] bad_ops [4] = '{7'h7F, 7'h73, 7'h0F, 7'h00};
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7), .br_en(br_en),
        .mem_addr_lo(mem_addr_lo), .mem_resp(mem_resp), .load_pc(load_pc), .load_ir(load_ir),
        .load_regfile(load_regfile), .load_mar(load_mar), .load_mdr(load_mdr),
        .load_data_out(load_data_out), .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel),
        .alumux2_sel(alumux2_sel), .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel),
        .cmpmux_sel(cmpmux_sel), .aluop(aluop), .cmpop(cmpop), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .commit(commit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called with the DUT in FETCH1 at a sample point; returns at the next instruction's FETCH1.
    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f75, input logic br,
                       input logic [1:0] lo, input int fw, input int dw);
        bit is_ld, is_st, is_slt, done, got_ir;
        int n, nmar, nrd, nwr, nrf, waited, e_lat;
        int e_rf, e_rfmux, e_pcmux, e_alu, e_m1, e_m2, e_cop, e_cmux;
        is_ld = op == OP_LOAD;
        is_st = op == OP_STORE;
        is_slt = f3 == 3'd2 || f3 == 3'd3;
        {e_rf, e_rfmux, e_pcmux, e_alu, e_m1, e_m2, e_cop, e_cmux} = '0;
        case (op)
            OP_IMM: begin
                e_rf = 1;
                e_alu = (f3 == 5 && f75) ? 2 : int'(f3);
                if (is_slt) begin e_rfmux = 1; e_cmux = 1; e_cop = f3 == 2 ? 4 : 6; end
            end
            OP_REG: begin
                e_rf = 1; e_m2 = 5;
                e_alu = (f3 == 5 && f75) ? 2 : (f3 == 0 && f75) ? 3 : int'(f3);
                if (is_slt) begin e_rfmux = 1; e_cop = f3 == 2 ? 4 : 6; end
            end
            OP_BR:    begin e_pcmux = int'(br); e_m1 = 1; e_m2 = 2; e_cop = int'(f3); end
            OP_LUI:   begin e_rf = 1; e_rfmux = 2; end
            OP_AUIPC: begin e_rf = 1; e_m1 = 1; e_m2 = 1; end
            OP_JAL:   begin e_rf = 1; e_rfmux = 4; e_m1 = 1; e_m2 = 4; e_pcmux = 1; end
            OP_JALR:  begin e_rf = 1; e_rfmux = 4; e_pcmux = 2; end
            OP_LOAD:  begin e_rf = 1; e_rfmux = f3 == 0 ? 5 : f3 == 1 ? 7 : f3 == 4 ? 6 : f3 == 5 ? 8 : 3; end
            default: ;
        endcase
        e_lat = (is_ld || is_st) ? 7 + fw + dw : 5 + fw;
        opcode = op; funct3 = f3; funct7 = {1'b0, f75, 5'b0}; br_en = br; mem_addr_lo = lo;
        #1;
        {n, nmar, nrd, nwr, nrf, waited} = '0;
        done = 0; got_ir = 0;
        for (int k = 0; k < 64 && !done; k++) begin
            n++;
            nrd += int'(mem_read); nwr += int'(mem_write); nrf += int'(load_regfile);
            if (load_mar) begin
                nmar++;
                if (nmar == 2) begin
                    chk("calc_marmux", marmux_sel, 1);
                    chk("calc_alumux2", alumux2_sel, is_st ? 3 : 0);
                    chk("calc_data_out", load_data_out, is_st);
                end
            end
            if (mem_write && nwr == 1)
                chk("store_be", mem_byte_enable, f3 == 2 ? 15 : ((f3 == 1 ? 3 : 1) << lo) & 15);
            if (mem_read || mem_write) begin
                mem_resp = waited == (got_ir ? dw : fw);
                waited++;
            end else begin
                waited = 0;
                mem_resp = 1'($urandom);
            end
            if (load_ir) got_ir = 1;
            if (commit) begin
                done = 1;
                chk("latency", n, e_lat);
                chk("load_regfile", load_regfile, e_rf);
                chk("load_pc", load_pc, 1);
                chk("pcmux", pcmux_sel, e_pcmux);
                chk("regfilemux", regfilemux_sel, e_rfmux);
                chk("alumux1", alumux1_sel, e_m1);
                chk("alumux2", alumux2_sel, e_m2);
                chk("aluop", aluop, e_alu);
                chk("cmpop", cmpop, e_cop);
                chk("cmpmux", cmpmux_sel, e_cmux);
                chk("commit_be", mem_byte_enable, 15);
                chk("regfile_writes", nrf, e_rf);
                chk("read_cycles", nrd, 1 + fw + (is_ld ? 1 + dw : 0));
                chk("write_cycles", nwr, is_st ? 1 + dw : 0);
                chk("mar_loads", nmar, (is_ld || is_st) ? 2 : 1);
            end
            @(negedge clk); #1;
        end
        chk("commit_seen", done, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_commit", commit, 0);
        chk("rst_load_regfile", load_regfile, 0);
        chk("rst_be", mem_byte_enable, 15);
        rst = 0;
        #1 chk("rel_fetch1", load_mar, 1);
        @(negedge clk); #1;
        chk("fetch2_read", mem_read, 1);
        rst = 1;
        #1 chk("abort_read", mem_read, 0);
        mem_resp = 1;
        @(negedge clk); rst = 0;
        #1 chk("post_rst_fetch1", load_mar, 1);
        @(negedge clk); #1;
        chk("post_rst_fetch2", mem_read, 1);
        rst = 1;
        @(negedge clk); rst = 0;
        #1;
        run(OP_IMM, 3'd0, 1'b0, 1'b0, 2'd0, 0, 0);
        run(OP_BR, 3'd0, 1'b0, 1'b1, 2'd0, 0, 0);
        run(OP_BR, 3'd0, 1'b0, 1'b0, 2'd0, 0, 0);
        run(OP_STORE, 3'd0, 1'b0, 1'b0, 2'd2, 0, 3);
        run(OP_LOAD, 3'd5, 1'b0, 1'b0, 2'd0, 0, 2);
        run(7'h7F, 3'd0, 1'b0, 1'b0, 2'd0, 0, 0);
        run(OP_REG, 3'd0, 1'b1, 1'b0, 2'd0, 1, 0);
        run(OP_IMM, 3'd5, 1'b1, 1'b0, 2'd0, 0, 0);
        run(OP_STORE, 3'd1, 1'b0, 1'b0, 2'd3, 2, 1);
        for (int i = 0; i < 150; i++) begin
            int pick;
            logic [6:0] op;
            logic [2:0] f3;
            pick = $urandom_range(0, 9);
            op = pick == 9 ? bad_ops[$urandom_range(0, 3)] : legal_ops[pick];
            f3 = 3'($urandom);
            if (op == OP_LOAD) f3 = ld_f3[$urandom_range(0, 4)];
            if (op == OP_STORE) f3 = 3'($urandom_range(0, 2));
            if (op == OP_BR) f3 = br_f3[$urandom_range(0, 5)];
            run(op, f3, 1'($urandom), 1'($urandom), 2'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multicycle sequencer for the RV32I datapath. It decodes the IR fields and branch result that the datapath exports and drives every register load, mux select and ALU/CMP op.
- It owns the memory handshake: mem_read, mem_write and mem_byte_enable, qualified by mem_resp.
- It sits beside the datapath in the CPU top and retires one instruction at a time.

Parameters:
- None. All encodings come from the shared package.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  rv32i_opcode from IR.
- funct3  in  3  IR funct3.
- funct7  in  7  IR funct7; only bit 5 is used.
- br_en  in  1  CMP result.
- mem_addr_lo  in  2  MAR[1:0], for store byte enables.
- mem_resp  in  1  memory completes the current read or write this cycle.
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out  out  1 each  datapath register loads.
- pcmux_sel  out  2  0 pc+4, 1 alu_out, 2 alu_out&~1.
- alumux1_sel  out  1  0 rs1, 1 pc.
- alumux2_sel  out  3  0 i_imm, 1 u_imm, 2 b_imm, 3 s_imm, 4 j_imm, 5 rs2.
- regfilemux_sel  out  4  0 alu, 1 br_en, 2 u_imm, 3 lw, 4 pc+4, 5 lb, 6 lbu, 7 lh, 8 lhu.
- marmux_sel  out  1  0 pc, 1 alu_out.
- cmpmux_sel  out  1  0 rs2, 1 i_imm.
- aluop  out  3  alu_ops enum.
- cmpop  out  3  branch_funct3_t.
- mem_read, mem_write  out  1 each  memory strobes.
- mem_byte_enable  out  4  write lane mask.
- commit  out  1  one-cycle pulse on the final cycle of each instruction.

Behaviour:
- Output style: Moore outputs, a function of state plus IR fields only. No output depends on mem_resp.
- Defaults: every load and strobe is 0, and every select and op is 0. mem_byte_enable defaults to 4'b1111.
- Reset: rst=1 forces state FETCH1 immediately. All outputs take their defaults, so an in-flight memory access is abandoned with mem_read=mem_write=0. The first edge after rst deasserts executes FETCH1.
- FETCH1: marmux=pc, load_mar -> FETCH2.
- FETCH2: mem_read=1, load_mdr=1. Hold while mem_resp=0; on mem_resp -> FETCH3.
- FETCH3: load_ir -> DECODE.
- DECODE: one cycle, no loads. Dispatch on opcode:
  - op_imm -> IMM; op_reg -> REG; op_br -> BR; op_lui -> LUI; op_auipc -> AUIPC; op_jal -> JAL; op_jalr -> JALR; op_load/op_store -> CALC_ADDR.
  - Any other opcode -> ILLEGAL.
- IMM: alumux2=i_imm, regfilemux=alu, aluop=funct3.
  - funct3=101 with funct7[5]=1: aluop=sra.
  - slti/sltiu: cmpmux=i_imm, cmpop=blt/bltu, regfilemux=br_en.
  - load_regfile, load_pc (pc+4), commit -> FETCH1.
- REG: alumux2=rs2.
  - funct3=000 with funct7[5]=1: aluop=sub.
  - 101 with funct7[5]=1: aluop=sra.
  - slt/sltu: cmpmux=rs2, cmpop=blt/bltu, regfilemux=br_en.
  - Then as IMM.
- BR: cmpop=funct3, cmpmux=rs2, alumux1=pc, alumux2=b_imm, aluop=add. pcmux=br_en?1:0. load_pc, commit -> FETCH1.
- LUI: regfilemux=u_imm, load_regfile, load_pc, commit.
- AUIPC: alumux1=pc, alumux2=u_imm, add, regfilemux=alu, load_regfile, load_pc, commit.
- JAL: regfilemux=pc+4, load_regfile, alumux1=pc, alumux2=j_imm, add, pcmux=1, load_pc, commit.
- JALR: regfilemux=pc+4, load_regfile, alumux1=rs1, alumux2=i_imm, add, pcmux=2, load_pc, commit.
- CALC_ADDR: alumux1=rs1, aluop=add, marmux=alu_out, load_mar. alumux2=i_imm for loads and s_imm for stores. Stores also assert load_data_out. Load -> LD1; store -> ST1.
- LD1: mem_read=1, load_mdr=1. Hold until mem_resp -> LD2.
- LD2: regfilemux from funct3: lb 5, lh 7, lw 3, lbu 6, lhu 8. load_regfile, load_pc, commit -> FETCH1.
- ST1: mem_write=1, held until mem_resp -> ST2. Byte enable from funct3:
  - sw: 1111.
  - sh: 0011<<mem_addr_lo.
  - sb: 0001<<mem_addr_lo.
- ST2: load_pc, commit -> FETCH1.
- ILLEGAL: load_pc (pc+4), commit -> FETCH1. This skips the instruction; no register or memory write.
- Latency with zero-wait memory (mem_resp on first request cycle):
  - ALU, branch, lui, auipc, jal, jalr: 5 cycles.
  - Load and store: 7 cycles.
  - Each extra wait cycle adds 1.
- rs1/rs2 are not consumed. Misalignment and x0 writes are handled by the datapath.

Decomposition:
- State enum and the mux-select enums belong in the shared package next to the existing rv32i_types:
  - pcmux, alumux, regfilemux, marmux, cmpmux selects.
  - alu_ops, branch_funct3_t, load/store/arith funct3 enums.
- Single module. The state register is one always_ff with async reset; next-state logic and output decode are always_comb blocks.
- No sub-module is warranted.

Test Plan:
- rst pulsed mid-FETCH2 with mem_read=1 -> mem_read drops in the same cycle. With mem_resp held high, the next edge after release is FETCH1 (load_mar=1).
- addi (opcode 0010011, funct3 000), mem_resp tied 1 -> load_regfile=1, regfilemux=0, aluop=add, commit=1 on cycle 5 and only there.
- beq with br_en=1 -> pcmux_sel=1, alumux2_sel=2 at BR. With br_en=0 -> pcmux_sel=0.
- sb with mem_addr_lo=2'b10, mem_resp delayed 3 cycles -> mem_write high 4 cycles, mem_byte_enable=4'b0100, commit on cycle 10.
- lhu with 2 wait states -> regfilemux_sel=8 with load_regfile at LD2, total 9 cycles.
- opcode 7'b1111111 -> no load_regfile or mem_write; load_pc with pcmux_sel=0 and commit on cycle 5.
